// File: rtl/frame_buffer_swap.sv
// -----------------------------------------------------------------------------
// frame_buffer_swap
//
// Double-buffered 12-bit framebuffer in the pixel clock domain. The display
// reads the front bank through a registered read port. The renderer writes the
// back bank through a valid/ready port. A swap request is held until the first
// cycle of vertical blanking, so the display never shows a torn frame.
//
// Optional feature (compile-time macro FB_CLEAR_EN):
//   After every swap, the new back bank is filled with CLEAR_COLOR, one word
//   per cycle (DEPTH cycles). While this runs, busy=1 and wr_ready=0.
//   Without the macro there is no CLEAR state and no clear counter.
//
// Ports:
//   clk_pixel     in   pixel clock
//   rstn_pixel    in   asynchronous, active-low reset
//   read_addr     in   display read address (>= DEPTH reads as 12'h000)
//   read_data     out  front-bank word, 1-cycle latency, {b[11:8],g[7:4],r[3:0]}
//   vblank_start  in   one-cycle pulse on the first vblank cycle
//   wr_valid      in   renderer write request
//   wr_ready      out  write port accepts a request (IDLE only)
//   wr_addr       in   back-bank write address (>= DEPTH accepted, discarded)
//   wr_data       in   back-bank write data
//   swap_req      in   one-cycle request to swap at the next vblank
//   swap_done     out  one-cycle pulse, first cycle front_sel shows new bank
//   front_sel     out  index of the displayed bank
//   busy          out  a swap (or clear) is pending
//
// Handshake: a write transfers on every rising edge where wr_valid && wr_ready.
// While wr_valid && !wr_ready, the renderer holds wr_addr/wr_data stable.
// wr_ready does not depend on wr_valid.
// -----------------------------------------------------------------------------
module frame_buffer_swap #(
  parameter int          DEPTH       = 19200,
  parameter int          ADDR_WIDTH  = 15,
  parameter logic [11:0] CLEAR_COLOR = 12'h000
) (
  input  logic                  clk_pixel,
  input  logic                  rstn_pixel,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [11:0]           read_data,
  input  logic                  vblank_start,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [11:0]           wr_data,
  input  logic                  swap_req,
  output logic                  swap_done,
  output logic                  front_sel,
  output logic                  busy
);

`ifdef FB_CLEAR_EN
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_VBLANK = 2'd1,
    CLEAR       = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_VBLANK = 2'd1
  } state_t;
`endif

  // One extra bit so that DEPTH == 2^ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_front_sel;
  logic                  r_swap_done;
  logic [11:0]           r_read_data;
  logic [11:0]           r_bank0 [0:DEPTH-1];
  logic [11:0]           r_bank1 [0:DEPTH-1];

  logic                  w_wr_ready;
  logic                  w_busy;
  logic                  w_rd_in_range;
  logic                  w_wr_in_range;
  logic                  w_swap_fire;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [11:0]           w_wdata;

  assign w_rd_in_range = ({1'b0, read_addr} < LP_DEPTH);
  assign w_wr_in_range = ({1'b0, wr_addr} < LP_DEPTH);
  // A vblank seen in the swap_req cycle itself is still in IDLE and ignored.
  assign w_swap_fire   = (r_state == WAIT_VBLANK) && vblank_start;

`ifdef FB_CLEAR_EN
  localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(DEPTH - 1);

  logic [ADDR_WIDTH-1:0] r_clr_addr;
  logic                  w_clr_active;
  logic                  w_clr_last;

  assign w_clr_active = (r_state == CLEAR);
  assign w_clr_last   = (r_clr_addr == LP_LAST);

  always_ff @(posedge clk_pixel or negedge rstn_pixel) begin
    if (!rstn_pixel) begin
      r_clr_addr <= '0;
    end else if (w_clr_active) begin
      r_clr_addr <= r_clr_addr + 1'b1;
    end else begin
      r_clr_addr <= '0;
    end
  end

  // Clear and renderer writes never overlap: wr_ready is low in CLEAR.
  assign w_we    = w_clr_active | (wr_valid & w_wr_ready & w_wr_in_range);
  assign w_waddr = w_clr_active ? r_clr_addr : wr_addr;
  assign w_wdata = w_clr_active ? CLEAR_COLOR : wr_data;
`else
  assign w_we    = wr_valid & w_wr_ready & w_wr_in_range;
  assign w_waddr = wr_addr;
  assign w_wdata = wr_data;
`endif

  // FSM state register
  always_ff @(posedge clk_pixel or negedge rstn_pixel) begin
    if (!rstn_pixel) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state and outputs
  always_comb begin
    w_state_next = r_state;
    w_wr_ready   = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      IDLE: begin
        w_wr_ready = 1'b1;
        w_busy     = 1'b0;
        if (swap_req) begin
          w_state_next = WAIT_VBLANK;
        end
      end
      WAIT_VBLANK: begin
        if (vblank_start) begin
`ifdef FB_CLEAR_EN
          w_state_next = CLEAR;
`else
          w_state_next = IDLE;
`endif
        end
      end
`ifdef FB_CLEAR_EN
      CLEAR: begin
        if (w_clr_last) begin
          w_state_next = IDLE;
        end
      end
`endif
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Bank select and swap pulse. swap_done lands on the same edge as the
  // toggle, so it coincides with the first cycle of the new front_sel.
  always_ff @(posedge clk_pixel or negedge rstn_pixel) begin
    if (!rstn_pixel) begin
      r_front_sel <= 1'b0;
      r_swap_done <= 1'b0;
    end else begin
      r_swap_done <= w_swap_fire;
      if (w_swap_fire) begin
        r_front_sel <= ~r_front_sel;
      end
    end
  end

  // Back-bank write port (bank ~front_sel). Contents are not reset.
  always_ff @(posedge clk_pixel) begin
    if (w_we && r_front_sel) begin
      r_bank0[w_waddr] <= w_wdata;
    end
    if (w_we && !r_front_sel) begin
      r_bank1[w_waddr] <= w_wdata;
    end
  end

  // Front-bank registered read. It uses the front_sel value from the current
  // cycle, so the read in the vblank_start cycle still sees the old bank.
  always_ff @(posedge clk_pixel or negedge rstn_pixel) begin
    if (!rstn_pixel) begin
      r_read_data <= 12'h000;
    end else if (!w_rd_in_range) begin
      r_read_data <= 12'h000;
    end else if (r_front_sel) begin
      r_read_data <= r_bank1[read_addr];
    end else begin
      r_read_data <= r_bank0[read_addr];
    end
  end

  assign read_data = r_read_data;
  assign wr_ready  = w_wr_ready;
  assign busy      = w_busy;
  assign swap_done = r_swap_done;
  assign front_sel = r_front_sel;

endmodule

// File: tb/tb_frame_buffer_swap.sv
// -----------------------------------------------------------------------------
// tb_frame_buffer_swap
//
// Randomized bench for frame_buffer_swap. The reference model keeps two banks
// as plain arrays plus a per-word "known" flag, and a displayed-bank index.
// Writes go to the non-displayed bank. A completed swap flips the index.
// Reads are scored through an expected queue, one cycle behind the address.
// -----------------------------------------------------------------------------
module tb_frame_buffer_swap;
  localparam int          DEPTH = 19200;
  localparam int          AW    = 15;
  localparam logic [11:0] CLR   = 12'h000;

  logic          clk_pixel;
  logic          rstn_pixel;
  logic [AW-1:0] read_addr;
  logic [11:0]   read_data;
  logic          vblank_start;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;
  logic          swap_req;
  logic          swap_done;
  logic          front_sel;
  logic          busy;

  frame_buffer_swap #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .CLEAR_COLOR(CLR)
  ) dut (
    .clk_pixel   (clk_pixel),
    .rstn_pixel  (rstn_pixel),
    .read_addr   (read_addr),
    .read_data   (read_data),
    .vblank_start(vblank_start),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .swap_req    (swap_req),
    .swap_done   (swap_done),
    .front_sel   (front_sel),
    .busy        (busy)
  );

  // ---------------------------------------------------------------- clock/reset
  initial begin
    clk_pixel = 1'b0;
    forever #5 clk_pixel = ~clk_pixel;
  end

  // ---------------------------------------------------------------- model
  logic [11:0] m_bank  [2][DEPTH];
  bit          m_known [2][DEPTH];
  int          m_fs;

  int n_checks;
  int n_errors;

  logic [11:0] exp_q[$];
  bit          vld_q[$];

  // {known, value}; out-of-range addresses always read as zero.
  function automatic logic [12:0] model_read(input int bank, input int addr);
    if (addr >= DEPTH) return 13'h1000;
    if (!m_known[bank][addr]) return 13'h0000;
    return {1'b1, m_bank[bank][addr]};
  endfunction

  function automatic void model_write(input int addr, input logic [11:0] data);
    if (addr < DEPTH) begin
      m_bank[1-m_fs][addr]  = data;
      m_known[1-m_fs][addr] = 1'b1;
    end
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  function automatic int pick_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return DEPTH;
    if (r == 1) return 32767;
    if (r == 2) return int'($urandom_range(DEPTH, 32767));
    if (r == 3) return int'($urandom_range(0, DEPTH - 1));
    return int'($urandom_range(0, 63));
  endfunction

  task automatic write_burst(input int n);
    int a;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_pixel);
      check("wr_ready_idle", {15'd0, wr_ready}, 16'd1);
      a        = pick_addr();
      wr_valid = ($urandom_range(0, 3) != 0);
      wr_addr  = AW'(a);
      wr_data  = 12'($urandom);
      if (wr_valid) model_write(a, wr_data);
    end
    @(negedge clk_pixel);
    wr_valid = 1'b0;
  endtask

  task automatic write_one(input int a, input logic [11:0] d);
    @(negedge clk_pixel);
    wr_valid = 1'b1;
    wr_addr  = AW'(a);
    wr_data  = d;
    model_write(a, d);
    @(negedge clk_pixel);
    wr_valid = 1'b0;
  endtask

  task automatic read_burst(input int n);
    int          a;
    logic [12:0] e;
    logic [11:0] ev;
    bit          vv;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk_pixel);
      if (exp_q.size() > 0) begin
        ev = exp_q.pop_front();
        vv = vld_q.pop_front();
        if (vv) check("read_data", {4'd0, read_data}, {4'd0, ev});
      end
      if (i < n) begin
        a = pick_addr();
        e = model_read(m_fs, a);
        exp_q.push_back(e[11:0]);
        vld_q.push_back(e[12]);
        read_addr = AW'(a);
      end
    end
  endtask

  // Full swap: request (with a write in the same cycle), wait, vblank.
  task automatic do_swap(input int wait_n, input bit same_vb, input bit extra_req,
                         input int probe);
    int          old_fs;
    int          cnt;
    int          wa;
    logic [12:0] e;
    old_fs = m_fs;
    @(negedge clk_pixel);
    swap_req     = 1'b1;
    vblank_start = same_vb;
    wa           = int'($urandom_range(8, 63));
    wr_valid     = 1'b1;
    wr_addr      = AW'(wa);
    wr_data      = 12'($urandom);
    model_write(wa, wr_data);
    @(negedge clk_pixel);
    swap_req     = 1'b0;
    vblank_start = 1'b0;
    wr_valid     = 1'b0;
    check("busy_wait", {15'd0, busy}, 16'd1);
    check("wr_ready_wait", {15'd0, wr_ready}, 16'd0);
    check("no_toggle_early", {15'd0, front_sel}, 16'(old_fs));
    for (int i = 0; i < wait_n; i++) begin
      @(negedge clk_pixel);
      swap_req = extra_req && (i == wait_n / 2);
      check("front_hold", {15'd0, front_sel}, 16'(old_fs));
      check("swap_done_low", {15'd0, swap_done}, 16'd0);
    end
    @(negedge clk_pixel);
    swap_req     = 1'b0;
    vblank_start = 1'b1;
    read_addr    = AW'(probe);
    check("front_before_vb", {15'd0, front_sel}, 16'(old_fs));
    @(negedge clk_pixel);
    vblank_start = 1'b0;
    check("front_toggled", {15'd0, front_sel}, 16'(1 - old_fs));
    check("swap_done_pulse", {15'd0, swap_done}, 16'd1);
    e = model_read(old_fs, probe);
    if (e[12]) check("read_old_bank", {4'd0, read_data}, {4'd0, e[11:0]});
    m_fs = 1 - old_fs;
`ifdef FB_CLEAR_EN
    check("busy_clear", {15'd0, busy}, 16'd1);
    for (int k = 0; k < DEPTH; k++) begin
      m_bank[1-m_fs][k]  = CLR;
      m_known[1-m_fs][k] = 1'b1;
    end
    cnt = 1;
`else
    check("busy_after_swap", {15'd0, busy}, 16'd0);
    check("wr_ready_after", {15'd0, wr_ready}, 16'd1);
    cnt = 0;
`endif
    @(negedge clk_pixel);
    check("swap_done_once", {15'd0, swap_done}, 16'd0);
    e = model_read(m_fs, probe);
    if (e[12]) check("read_new_bank", {4'd0, read_data}, {4'd0, e[11:0]});
`ifdef FB_CLEAR_EN
    if (busy) cnt++;
    while (busy && cnt < DEPTH + 16) begin
      @(negedge clk_pixel);
      if (busy) cnt++;
    end
    check("clear_cycles", 16'(cnt), 16'(DEPTH));
    check("wr_ready_post_clr", {15'd0, wr_ready}, 16'd1);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_front"}, {15'd0, front_sel}, 16'd0);
    check({tag, "_rdata"}, {4'd0, read_data}, 16'd0);
    check({tag, "_done"}, {15'd0, swap_done}, 16'd0);
    check({tag, "_busy"}, {15'd0, busy}, 16'd0);
    check({tag, "_ready"}, {15'd0, wr_ready}, 16'd1);
  endtask

  task automatic vblank_no_toggle(input string tag);
    @(negedge clk_pixel);
    vblank_start = 1'b1;
    @(negedge clk_pixel);
    vblank_start = 1'b0;
    check({tag, "_front"}, {15'd0, front_sel}, 16'(m_fs));
    check({tag, "_done"}, {15'd0, swap_done}, 16'd0);
    @(negedge clk_pixel);
    check({tag, "_front2"}, {15'd0, front_sel}, 16'(m_fs));
    check({tag, "_busy"}, {15'd0, busy}, 16'd0);
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    n_checks     = 0;
    n_errors     = 0;
    m_fs         = 0;
    read_addr    = '0;
    vblank_start = 1'b0;
    wr_valid     = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    swap_req     = 1'b0;
    rstn_pixel   = 1'b1;
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < DEPTH; k++) m_known[b][k] = 1'b0;

    #1 rstn_pixel = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(negedge clk_pixel);
    rstn_pixel = 1'b1;
    @(negedge clk_pixel);
    check_reset_outputs("post_reset");

    // First frame: random writes plus the 0xABC marker, swap after 100 cycles.
    write_burst(150);
    write_one(5, 12'hABC);
    write_one(DEPTH, 12'hFFF);
    write_one(32767, 12'hEEE);
    do_swap(100, 1'b0, 1'b0, 5);
    read_burst(200);

    // Second frame: old bank value is visible in the vblank-cycle read.
    write_burst(150);
    write_one(5, 12'h5A5);
    do_swap(20, 1'b0, 1'b0, 5);
    read_burst(200);

    // swap_req with vblank in the same cycle, plus an ignored second request.
    write_burst(100);
    do_swap(30, 1'b1, 1'b1, 7);
    vblank_no_toggle("extra_req");
    read_burst(200);

    // Reset during WAIT_VBLANK (front_sel is 1 here).
    @(negedge clk_pixel);
    swap_req = 1'b1;
    @(negedge clk_pixel);
    swap_req = 1'b0;
    repeat (5) @(negedge clk_pixel);
    #2 rstn_pixel = 1'b0;
    #1 check_reset_outputs("rst_wait");
    @(negedge clk_pixel);
    rstn_pixel = 1'b1;
    m_fs = 0;
    vblank_no_toggle("rst_wait_vb");
    read_burst(100);

`ifdef FB_CLEAR_EN
    // Reset part-way through a clear; the bank being cleared becomes unknown.
    @(negedge clk_pixel);
    swap_req = 1'b1;
    @(negedge clk_pixel);
    swap_req = 1'b0;
    repeat (3) @(negedge clk_pixel);
    vblank_start = 1'b1;
    @(negedge clk_pixel);
    vblank_start = 1'b0;
    repeat (100) @(negedge clk_pixel);
    check("busy_mid_clear", {15'd0, busy}, 16'd1);
    #2 rstn_pixel = 1'b0;
    #1 check_reset_outputs("rst_clear");
    for (int k = 0; k < DEPTH; k++) m_known[0][k] = 1'b0;
    @(negedge clk_pixel);
    rstn_pixel = 1'b1;
    m_fs = 0;
    vblank_no_toggle("rst_clear_vb");
    read_burst(100);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
